// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: loads A/B, compares MSB-first one bit per clock.
// Build option SERIAL_CMP_EARLY_TERM_EN finishes on the first differing bit instead of after WIDTH steps.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic bit_a, bit_b, diff, last_step, run_stop;

    assign bit_a     = sa_q[WIDTH-1];
    assign bit_b     = sb_q[WIDTH-1];
    assign diff      = bit_a ^ bit_b;
    assign last_step = (cnt_q == CNT_W'(1));

`ifdef SERIAL_CMP_EARLY_TERM_EN
    assign run_stop = last_step || (diff && !decided_q);
`else
    assign run_stop = last_step;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (run_stop) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_DONE);
        eq    = eq_q;
        gt    = gt_q;
        lt    = lt_q;
    end

    // Datapath: operand shifters, step counter, sticky decision and result flags.
    always_comb begin
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d      = a;
                    sb_d      = b;
                    cnt_d     = CNT_W'(WIDTH);
                    decided_d = 1'b0;
                    eq_d      = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                end
            end
            S_RUN: begin
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                // Only the first differing bit decides; later bits are ignored.
                if (diff && !decided_q) begin
                    decided_d = 1'b1;
                    gt_d      = bit_a;
                    lt_d      = ~bit_a;
                end
                if (run_stop) begin
                    eq_d = ~(decided_q | diff);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and random checks of serial_mag_comparator at WIDTH=8 (either build of SERIAL_CMP_EARLY_TERM_EN).
module tb_serial_mag_comparator;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         ready, done, eq, gt, lt;

    int n_tests = 0;
    int n_fail  = 0;
    int last_dec;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edges from the accepting edge until done is visible.
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_TERM_EN
        for (int i = W - 1; i >= 0; i--)
            if (x[i] != y[i]) return W - i;
        return W;
`else
        return W;
`endif
    endfunction

    function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y);
        return {x == y, x > y, x < y};
    endfunction

    // Waits for done; returns edge count (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int e = 1; e <= W + 4 && lat == 0; e++) begin
            @(posedge clk); #1;
            if ((gt | lt) && last_dec == 0) last_dec = e;
            if (done) lat = e;
        end
    endtask

    // Called 1ns after a rising edge with the block idle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int lat;
        logic [2:0] r;
        r = exp_res(x, y);
        check({tag, "_ready_pre"}, ready, 1);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        check({tag, "_ready_run"}, ready, 0);
        check({tag, "_cleared"}, {eq, gt, lt}, 3'b000);
        last_dec = 0;
        wait_done(lat);
        check({tag, "_latency"}, lat, exp_lat(x, y));
        check({tag, "_result"}, {eq, gt, lt}, r);
        check({tag, "_onehot"}, $countones({eq, gt, lt}), 1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_post"}, ready, 1);
        check({tag, "_hold"}, {eq, gt, lt}, r);
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_res", {eq, gt, lt}, 3'b000);
        #5 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_res", {eq, gt, lt}, 3'b000);

        do_op(8'hA5, 8'hA5, "eq_a5");
        do_op(8'h80, 8'h7F, "gt_80_7f");
        do_op(8'h12, 8'h13, "lt_12_13");
        check("lt_12_13_late_decision", last_dec, W);

        // Back-to-back with start held high.
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h00;
        check("b2b_busy1", ready, 0);
        last_dec = 0;
        wait_done(lat);
        check("b2b_lat1", lat, exp_lat(8'h00, 8'hFF));
        check("b2b_res1", {eq, gt, lt}, 3'b001);
        check("b2b_ready_in_done", ready, 0);
        @(posedge clk); #1;
        check("b2b_idle_gap", ready, 1);
        check("b2b_no_done", done, 0);
        @(posedge clk); #1;
        check("b2b_accept2", ready, 0);
        check("b2b_cleared2", {eq, gt, lt}, 3'b000);
        last_dec = 0;
        wait_done(lat);
        check("b2b_lat2", lat, exp_lat(8'hFF, 8'h00));
        check("b2b_res2", {eq, gt, lt}, 3'b010);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_ready_end", ready, 1);

        // Asynchronous reset mid-RUN.
        a = 8'h55; b = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_res", {eq, gt, lt}, 3'b000);
        @(posedge clk); #4 reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_idle", ready, 1);
        do_op(8'h3C, 8'h3C, "post_reset_eq");

        // Random sweep with a few forced equal pairs.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = (i % 8 == 0) ? x : W'($urandom);
            do_op(x, y, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Sequential counterpart to the gate-level equality/greater-than comparators.
- Loads two WIDTH-bit operands in parallel and compares them one bit per clock, MSB first.
- Each step uses a 1-bit equality/greater decision.
- Reports eq/gt/lt with a ready/start/done handshake.
- Used where a slow, tiny comparator is preferred over a wide combinational tree.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a comparison; sampled only while ready=1.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- ready  output  1  block idle; a start will be accepted.
- done  output  1  one-cycle pulse; results are valid this cycle.
- eq  output  1  A == B.
- gt  output  1  A > B (unsigned).
- lt  output  1  A < B (unsigned).

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset, while reset_n=0: state=IDLE, ready=1, done=0, eq=gt=lt=0, shift registers and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On a rising edge with start=1: capture a and b into shift registers sa and sb; clear the decided flag, gt and lt; set eq=0; load bit counter=WIDTH; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - ready=0. Each edge examines sa[WIDTH-1] and sb[WIDTH-1].
  - If not yet decided and the bits differ: set decided; set gt if the A bit is 1, else set lt.
  - Bits after the decision do not change the result.
  - Shift sa and sb left by one; decrement the counter.
  - When the counter reaches 0, go to DONE on the same edge. On that edge, set eq=~decided if no difference has been found.
- DONE: done=1 for exactly one cycle; ready=0; next edge goes to IDLE.
- Latency (no macro): start sampled at edge 0 -> done=1 during the cycle after edge WIDTH. One operation occupies WIDTH+2 cycles, IDLE cycle included.
- Result outputs:
  - Registered.
  - Exactly one of eq/gt/lt is 1 from the done cycle until the next accepted start. The accepted start clears all three.
  - All three are 0 after reset, before the first done.
- start while ready=0 is ignored and not queued. a and b may change freely after the capture edge.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is emitted for the aborted operation.
- Unsigned comparison only; no sign handling.
- Counter width: $clog2(WIDTH+1).

Optional Feature:
- Macro: SERIAL_CMP_EARLY_TERM_EN.
- Defined:
  - On the edge where the first differing bit is detected, the FSM goes straight to DONE with gt/lt set.
  - Latency = k+1 edges, where k is the 0-based index of the first differing bit counted from the MSB. done appears in the cycle after edge k+1.
  - Equal operands still take WIDTH.
- Not defined: fixed WIDTH-cycle latency for all operands, as above.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start one cycle -> done high exactly in the cycle after edge 8; eq=1, gt=lt=0; ready=1 one cycle later.
- a=0x80, b=0x7F -> gt=1. done after 8 edges without the macro; after edge 1 with SERIAL_CMP_EARLY_TERM_EN.
- a=0x12, b=0x13 -> lt=1, latency 8 edges in both builds. Check that the decision on bit 0 is taken only at the last step.
- a=0x00, b=0xFF, then a=0xFF, b=0x00, back-to-back with start held high continuously:
  - Results are lt, then gt.
  - Second start is accepted only in the first cycle with ready=1.
  - No start is accepted during RUN/DONE.
- Pulse reset_n low asynchronously mid-RUN (3 edges after start) -> ready=1 and eq=gt=lt=done=0 immediately, no done pulse. After release, a=0x3C vs b=0x3C gives eq=1.
- Random sweep, 1000 operand pairs, checked against a reference model of A==B and A>B -> exactly one of eq/gt/lt is 1 at every done; correct latency for the build.
